// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB software register bank.
// Register modes, ack FSM states and the OPB byte-lane merge live here.
package opb_reg_pkg;

    localparam int REG_W    = 32;
    localparam int MAX_REGS = 64;

    typedef enum logic [1:0] {
        MODE_RW    = 2'd0,
        MODE_RO    = 2'd1,
        MODE_PULSE = 2'd2
    } reg_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

    // be[3] is OPB_BE[0], the most significant byte lane (user bits 31:24).
    function automatic logic [REG_W-1:0] be_merge(
        input logic [REG_W-1:0] old_val,
        input logic [REG_W-1:0] data,
        input logic [3:0]       be
    );
        logic [REG_W-1:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = data[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// One software register slot: read/write with byte enables, self-clearing
// pulse bits, or a read-only status shadow sampled every clock.
module opb_reg_slice
    import opb_reg_pkg::*;
#(
    parameter reg_mode_t MODE = MODE_RW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [REG_W-1:0] wr_data,
    input  logic [3:0]       be,
    input  logic [REG_W-1:0] status_in,
    output logic [REG_W-1:0] value,
    output logic [REG_W-1:0] data_out,
    output logic             wr_stb
);

    generate
        if (MODE == MODE_RO) begin : g_ro
            logic [REG_W-1:0] status_q;

            always_ff @(posedge clk) begin
                if (rst) status_q <= '0;
                else     status_q <= status_in;
            end

            assign value    = status_q;
            assign data_out = '0;
            assign wr_stb   = 1'b0;
            wire unused_wr = ^{wr_en, wr_data, be};
        end else begin : g_rw
            logic [REG_W-1:0] reg_q;
            logic             stb_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    reg_q <= '0;
                    stb_q <= 1'b0;
                end else begin
                    stb_q <= wr_en;
                    // Pulse bits live for the single cycle after the write.
                    if (MODE == MODE_PULSE)
                        reg_q <= wr_en ? be_merge('0, wr_data, be) : '0;
                    else if (wr_en)
                        reg_q <= be_merge(reg_q, wr_data, be);
                end
            end

            assign value    = reg_q;
            assign data_out = reg_q;
            assign wr_stb   = stb_q;
            wire unused_status = ^status_in;
        end
    endgenerate

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave with C_NUM_REGS 32-bit software registers. Transfers are acked
// one cycle after the hit; the cycle after an ack never starts a new transfer.
module opb_register_bank
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter logic [63:0] C_RO_MASK    = 64'd0,
    parameter logic [63:0] C_PULSE_MASK = 64'd0,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:31]                 OPB_ABus,
    input  logic [0:3]                  OPB_BE,
    input  logic [0:31]                 OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:31]                 Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]    user_data_out,
    output logic [C_NUM_REGS-1:0]       user_wr_stb,
    input  logic [32*C_NUM_REGS-1:0]    user_data_in
);

    ack_state_t       state;
    logic [31:0]      offset;
    logic [31:0]      idx;
    logic             in_range;
    logic             hit;
    logic [REG_W-1:0] wr_data;
    logic [3:0]       be;
    logic [REG_W-1:0] rd_sel;
    logic [REG_W-1:0] rd_q;
    logic [REG_W-1:0] values [C_NUM_REGS];

    // Big-endian OPB buses map straight onto little-endian user vectors.
    assign wr_data  = OPB_DBus;
    assign be       = OPB_BE;
    assign offset   = OPB_ABus - C_BASEADDR;
    assign idx      = {2'b00, offset[31:2]};
    assign in_range = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign hit      = OPB_select && in_range && (state == ST_IDLE);

    genvar i;
    generate
        for (i = 0; i < C_NUM_REGS; i++) begin : g_slot
            localparam reg_mode_t MODE = C_RO_MASK[i]    ? MODE_RO :
                                         C_PULSE_MASK[i] ? MODE_PULSE : MODE_RW;
            opb_reg_slice #(.MODE(MODE)) u_slice (
                .clk       (OPB_Clk),
                .rst       (OPB_Rst),
                .wr_en     (hit && !OPB_RNW && (idx == 32'(i))),
                .wr_data   (wr_data),
                .be        (be),
                .status_in (user_data_in[32*i +: 32]),
                .value     (values[i]),
                .data_out  (user_data_out[32*i +: 32]),
                .wr_stb    (user_wr_stb[i])
            );
        end
    endgenerate

    // Indices past C_NUM_REGS inside the decoded span read as zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (idx == 32'(k)) rd_sel = values[k];
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state <= ST_IDLE;
            rd_q  <= '0;
        end else begin
            state <= hit ? ST_ACK : ST_IDLE;
            rd_q  <= (hit && OPB_RNW) ? rd_sel : '0;
        end
    end

    assign Sl_xferAck = (state == ST_ACK);
    assign Sl_DBus    = rd_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    wire unused_inputs = ^{OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed table-driven bench for opb_register_bank: reg 3 pulse, reg 5 read-only.
module tb_opb_register_bank;

    localparam logic [31:0] BASE = 32'h0108_0000;
    localparam logic [31:0] HIGH = 32'h0108_00FF;
    localparam int          NR   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [0:31]       abus = '0;
    logic [0:3]        be = '0;
    logic [0:31]       dbus = '0;
    logic              rnw = 1'b1;
    logic              sel = 1'b0;
    logic              seq_addr = 1'b0;
    logic [0:31]       sl_dbus;
    logic              sl_ack, sl_err, sl_retry, sl_tout;
    logic [32*NR-1:0]  udo;
    logic [NR-1:0]     stb;
    logic [32*NR-1:0]  udi = '0;

    int n_cmp = 0;
    int n_fail = 0;

    logic              got_ack;
    int                got_lat;
    logic [31:0]       got_rdata;
    logic [NR-1:0]     stb_ack, stb_after;
    logic [32*NR-1:0]  udo_ack, udo_after;
    logic              ack_after;

    always #5 clk = ~clk;

    opb_register_bank #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_NUM_REGS   (NR),
        .C_RO_MASK    (64'h20),
        .C_PULSE_MASK (64'h08)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq_addr),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (sl_ack),
        .Sl_errAck     (sl_err),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout),
        .user_data_out (udo),
        .user_wr_stb   (stb),
        .user_data_in  (udi)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transfer: select held until ack (bounded to 4 cycles), then one idle cycle.
    task automatic xfer(input logic [31:0] addr, input logic rd, input logic [31:0] data,
                        input logic [3:0] be_in, input logic [31:0] din5);
        @(negedge clk);
        abus = addr; rnw = rd; dbus = data; be = be_in; sel = 1'b1;
        udi[191:160] = din5;
        got_ack = 1'b0; got_lat = 0; got_rdata = '0;
        for (int k = 1; k <= 4 && !got_ack; k++) begin
            @(negedge clk);
            got_rdata = sl_dbus;
            if (sl_ack) begin
                got_ack = 1'b1; got_lat = k; stb_ack = stb; udo_ack = udo;
            end
        end
        sel = 1'b0;
        @(negedge clk);
        stb_after = stb; udo_after = udo; ack_after = sl_ack;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] din5;
        logic        exp_ack;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_stb;
    } vec_t;

    vec_t vecs[23];

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{BASE + 32'(4*i), 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 32'h0, 8'h00};
        vecs[8]  = '{BASE + 32'h08, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, 32'h0, 8'h04};
        vecs[9]  = '{BASE + 32'h08, 1'b0, 32'h11000000, 4'h8, 32'h0, 1'b1, 32'h0, 8'h04};
        vecs[10] = '{BASE + 32'h08, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 32'h11ADBEEF, 8'h00};
        vecs[11] = '{BASE + 32'h00, 1'b0, 32'h5A5A5AAA, 4'h1, 32'h0, 1'b1, 32'h0, 8'h01};
        vecs[12] = '{BASE + 32'h00, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 32'h000000AA, 8'h00};
        vecs[13] = '{BASE + 32'h1C, 1'b0, 32'h12345678, 4'h6, 32'h0, 1'b1, 32'h0, 8'h80};
        vecs[14] = '{BASE + 32'h1C, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 32'h00345600, 8'h00};
        vecs[15] = '{BASE + 32'h14, 1'b0, 32'hFFFFFFFF, 4'hF, 32'hCAFE0001, 1'b1, 32'h0, 8'h00};
        vecs[16] = '{BASE + 32'h14, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b1, 32'hCAFE0001, 8'h00};
        vecs[17] = '{BASE + 32'h80, 1'b0, 32'hFFFFFFFF, 4'hF, 32'hCAFE0001, 1'b1, 32'h0, 8'h00};
        vecs[18] = '{BASE + 32'h80, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b1, 32'h0, 8'h00};
        vecs[19] = '{BASE + 32'hFC, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b1, 32'h0, 8'h00};
        vecs[20] = '{HIGH + 32'h1,  1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b0, 32'h0, 8'h00};
        vecs[21] = '{BASE - 32'h4,  1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b0, 32'h0, 8'h00};
        vecs[22] = '{BASE + 32'h08, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b1, 32'h11ADBEEF, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(sl_ack), 32'h0);
        check("reset_dbus", sl_dbus, 32'h0);
        check("reset_stb", 32'(stb), 32'h0);
        check("reset_udo_or", 32'(|udo), 32'h0);
        check("tie_offs", {29'h0, sl_err, sl_retry, sl_tout}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            udi[191:160] = vecs[i].din5;
            xfer(vecs[i].addr, vecs[i].rd, vecs[i].data, vecs[i].be, vecs[i].din5);
            check($sformatf("v%0d_ack", i), 32'(got_ack), 32'(vecs[i].exp_ack));
            if (vecs[i].exp_ack) begin
                check($sformatf("v%0d_lat", i), 32'(got_lat), 32'd1);
                check($sformatf("v%0d_stb", i), 32'(stb_ack), 32'(vecs[i].exp_stb));
                check($sformatf("v%0d_ack_after", i), 32'(ack_after), 32'h0);
                check($sformatf("v%0d_stb_after", i), 32'(stb_after), 32'h0);
            end
            if (vecs[i].rd)
                check($sformatf("v%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
        end
        check("udo_reg2", udo[95:64], 32'h11ADBEEF);
        check("udo_reg5_ro_zero", udo[191:160], 32'h0);

        // Pulse register 3: visible for the ack cycle only
        xfer(BASE + 32'h0C, 1'b0, 32'h5, 4'hF, 32'hCAFE0001);
        check("pulse_ack", 32'(got_ack), 32'h1);
        check("pulse_udo_at_ack", udo_ack[127:96], 32'h5);
        check("pulse_nibble_at_ack", 32'(udo_ack[99:96]), 32'h5);
        check("pulse_stb", 32'(stb_ack), 32'h08);
        check("pulse_udo_after", udo_after[127:96], 32'h0);
        xfer(BASE + 32'h0C, 1'b1, 32'h0, 4'hF, 32'hCAFE0001);
        check("pulse_readback", got_rdata, 32'h0);

        // Status shadow adds a cycle: change lands with the select, old value read
        xfer(BASE + 32'h14, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
        check("status_old", got_rdata, 32'hCAFE0001);
        xfer(BASE + 32'h14, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
        check("status_new", got_rdata, 32'h0BADF00D);

        // Select held for 6 cycles: acks on alternate cycles only
        @(negedge clk);
        abus = BASE + 32'h08; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("held_ack_c%0d", c), 32'(sl_ack), 32'(c % 2));
            if (c % 2 == 1) check($sformatf("held_data_c%0d", c), sl_dbus, 32'h11ADBEEF);
        end
        sel = 1'b0;
        @(negedge clk);

        // Reset during a write hit: no ack, write lost
        abus = BASE + 32'h04; rnw = 1'b0; dbus = 32'h77; be = 4'hF; sel = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 32'(sl_ack), 32'h0);
        check("rst_mid_stb", 32'(stb), 32'h0);
        check("rst_mid_dbus", sl_dbus, 32'h0);
        sel = 1'b0; rst = 1'b0;
        xfer(BASE + 32'h04, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
        check("rst_mid_ack_later", 32'(got_ack), 32'h1);
        check("rst_mid_write_lost", got_rdata, 32'h0);
        xfer(BASE + 32'h08, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
        check("rst_clears_reg2", got_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/opb_register_bank.md
# opb_register_bank

Parametrised OPB slave holding `C_NUM_REGS` 32-bit software registers for PPC-to-fabric control and fabric-to-PPC status, replacing single-register ppc2simulink instances such as the bin-load control. Each register is independently read/write, read-only (status from fabric), or pulse (self-clearing strobe bits). Sits on the OPB alongside other slaves and presents flattened user buses to the DSP design.

## Interface
- `C_BASEADDR`, 32'h01080000, first byte address; register i at `C_BASEADDR + 4*i`
- `C_HIGHADDR`, 32'h010800FF, last decoded byte address (inclusive)
- `C_OPB_AWIDTH`, 32, OPB address width
- `C_OPB_DWIDTH`, 32, OPB data width (only 32 supported)
- `C_NUM_REGS`, 8, register count, 1..64; `4*C_NUM_REGS` must not exceed the decoded span
- `C_RO_MASK`, 0, bit i = 1: register i is read-only status
- `C_PULSE_MASK`, 0, bit i = 1: register i is pulse mode (ignored if RO)
- `C_FAMILY`, "virtex5", target family

Ports:
- `OPB_Clk` in 1, sole clock
- `OPB_Rst` in 1, reset; **one clock; reset is synchronous and active-high**
- `OPB_ABus` in [0:31], address
- `OPB_BE` in [0:3], byte enables; `BE[0]` ↔ `DBus[0:7]` ↔ user bits [31:24]
- `OPB_DBus` in [0:31], write data
- `OPB_RNW` in 1, 1 = read
- `OPB_select` in 1, transfer request
- `OPB_seqAddr` in 1, ignored
- `Sl_DBus` out [0:31], read data, zero except in ack cycle
- `Sl_xferAck` out 1, transfer acknowledge
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup` out 1 each, constant 0
- `user_data_out` out [32*C_NUM_REGS-1:0], register i on bits [32i+31:32i]; RO slots drive 0
- `user_wr_stb` out [C_NUM_REGS-1:0], one-cycle pulse after any write to register i
- `user_data_in` in [32*C_NUM_REGS-1:0], status inputs; used only for RO slots

## Operation
- Hit = `OPB_select` & `C_BASEADDR <= OPB_ABus <= C_HIGHADDR` & not `ack_q` (the cycle after an ack never starts a new transfer).
- Index = `(OPB_ABus - C_BASEADDR) >> 2`; index ≥ `C_NUM_REGS` inside range: acked, read returns 0, write discarded, no strobe.
- Write to RW slot: each byte with BE set replaced; others hold.
- Write to pulse slot: written 1-bits set for exactly one cycle, then clear to 0; written 0-bits have no effect.
- Write to RO slot: discarded, acked, `user_wr_stb` not asserted.
- Read: RW/pulse returns current register; RO returns `user_data_in` slice registered once on `OPB_Clk` (status register refreshed every cycle, no BE effect).
- Reset: all registers 0, status shadow 0, `Sl_xferAck` 0, `Sl_DBus` 0, `user_wr_stb` 0.
- Reset asserted mid-transfer: no ack emitted, pending write lost; master times out and retries.

## Timing
- Cycle T: hit sampled. Edge end of T: `ack_q`←1, write applied, read data latched.
- Cycle T+1: `Sl_xferAck`=1 for exactly one cycle, `Sl_DBus` valid (reads), `user_data_out` shows new value, `user_wr_stb[i]`=1.
- Cycle T+2: ack and data return to 0; pulse bits clear at end of T+1 (visible high during T+1 only).
- Read-after-write back-to-back returns the written value (T+2 earliest new hit).
- Read latency from status input change to `Sl_DBus`: status shadow adds one cycle.
- Select held continuously: ack every second cycle, never consecutive.

## Structure
- Package `opb_reg_pkg`: `REG_W`=32, `MAX_REGS`=64, mode encoding (RW/RO/PULSE), function `be_merge(old, data, be)` mapping OPB big-endian lanes.
- Sub-module `opb_reg_slice`: one register with BE merge, pulse clear and strobe, instantiated per slot via generate; top holds decode, ack FSM (IDLE/ACK), read mux.

## Test plan
- Reset, then read reg 0..7 -> all 0, each ack exactly one cycle after select.
- Write 0xDEADBEEF BE=1111 to reg 2, then BE=1000 data 0x11000000 -> readback 0x11ADBEEF; `user_wr_stb[2]` pulses twice.
- Pulse reg 3 (`C_PULSE_MASK`=8), write 0x5 -> `user_data_out[99:96]` = 0x5 for one cycle, then 0; readback 0.
- RO reg 5, `user_data_in` slice = 0xCAFE0001, write 0xFFFFFFFF -> read 0xCAFE0001, no strobe.
- Address `C_BASEADDR+0x80` (index 32 ≥ 8) write/read -> acked, read 0; address `C_HIGHADDR+1` -> no ack, `Sl_DBus`=0.
- Select held 6 cycles -> acks at cycles 1,3,5 only; `OPB_Rst` at T -> no ack at T+1.
